// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared mode codes, FSM state type and mode helpers for the mul/div unit
// Ports: none (package). Mode codes sit above the ALU's 8'h00-8'h19 range.
package muldiv_pkg;

    localparam logic [7:0] MODE_MUL    = 8'h20;
    localparam logic [7:0] MODE_MULH   = 8'h21;
    localparam logic [7:0] MODE_MULHSU = 8'h22;
    localparam logic [7:0] MODE_MULHU  = 8'h23;
    localparam logic [7:0] MODE_DIV    = 8'h24;
    localparam logic [7:0] MODE_DIVU   = 8'h25;
    localparam logic [7:0] MODE_REM    = 8'h26;
    localparam logic [7:0] MODE_REMU   = 8'h27;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Legal codes are exactly 8'b0010_0xxx.
    function automatic logic is_legal(input logic [7:0] mode);
        return (mode[7:3] == 5'b00100);
    endfunction

    // Divide-family codes are the legal ones with bit 2 set (8'h24..8'h27).
    function automatic logic is_div(input logic [7:0] mode);
        return is_legal(mode) && mode[2];
    endfunction

    function automatic logic is_rem(input logic [7:0] mode);
        return (mode == MODE_REM) || (mode == MODE_REMU);
    endfunction

    // rs1 is signed for MUL/MULH/MULHSU/DIV/REM.
    function automatic logic num1_signed(input logic [7:0] mode);
        return (mode == MODE_MUL) || (mode == MODE_MULH) || (mode == MODE_MULHSU) ||
               (mode == MODE_DIV) || (mode == MODE_REM);
    endfunction

    // rs2 is signed for MUL/MULH/DIV/REM (MULHSU treats rs2 as unsigned).
    function automatic logic num2_signed(input logic [7:0] mode);
        return (mode == MODE_MUL) || (mode == MODE_MULH) ||
               (mode == MODE_DIV) || (mode == MODE_REM);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request/response handshake bundle between pipeline and mul/div unit
// Signals: in_valid/in_ready/num1/num2/mode_sel (request), out_valid/out_ready/ans/error (response).
// master = pipeline side, slave = muldiv_unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] num1;
    logic [WIDTH-1:0] num2;
    logic [7:0]       mode_sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ans;
    logic             error;

    modport master (
        output in_valid, num1, num2, mode_sel, out_ready,
        input  in_ready, out_valid, ans, error
    );

    modport slave (
        input  in_valid, num1, num2, mode_sel, out_ready,
        output in_ready, out_valid, ans, error
    );
endinterface

// File: rtl/muldiv_signfix.sv
// rtl/muldiv_signfix.sv - combinational sign handling: operand magnitudes at accept, result fix-up at completion
// Inputs : mode/num1/num2 (accept side); fin_mode/fin_neg1/fin_neg2/prod/quot/rem (completion side).
// Outputs: mag1/mag2/neg1/neg2 (values to latch), result (sign-corrected, width-selected answer).
module muldiv_signfix
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [7:0]         mode,
    input  logic [WIDTH-1:0]   num1,
    input  logic [WIDTH-1:0]   num2,
    output logic [WIDTH-1:0]   mag1,
    output logic [WIDTH-1:0]   mag2,
    output logic               neg1,
    output logic               neg2,
    input  logic [7:0]         fin_mode,
    input  logic               fin_neg1,
    input  logic               fin_neg2,
    input  logic [2*WIDTH-1:0] prod,
    input  logic [WIDTH-1:0]   quot,
    input  logic [WIDTH-1:0]   rem,
    output logic [WIDTH-1:0]   result
);

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    // The most-negative value negates to itself, which is its correct
    // unsigned magnitude, so no special case is needed here.
    always_comb begin
        neg1 = num1_signed(mode) & num1[WIDTH-1];
        neg2 = num2_signed(mode) & num2[WIDTH-1];
        mag1 = neg1 ? -num1 : num1;
        mag2 = neg2 ? -num2 : num2;
    end

    always_comb begin
        prod_fix = (fin_neg1 ^ fin_neg2) ? -prod : prod;
        quot_fix = (fin_neg1 ^ fin_neg2) ? -quot : quot;
        // Remainder follows the dividend's sign.
        rem_fix  = fin_neg1 ? -rem : rem;
        case (fin_mode)
            MODE_MUL:                            result = prod_fix[WIDTH-1:0];
            MODE_MULH, MODE_MULHSU, MODE_MULHU:  result = prod_fix[2*WIDTH-1:WIDTH];
            MODE_DIV, MODE_DIVU:                 result = quot_fix;
            MODE_REM, MODE_REMU:                 result = rem_fix;
            default:                             result = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, one result bit per clock
// Ports: clk, rst (sync active-high), flush (sync abort), bus (muldiv_if.slave request/response).
// Multiply is radix-2 shift-add, divide is restoring shift-subtract; both share hi_q/lo_q.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     flush,
    muldiv_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [7:0]       mode_q;
    logic             neg1_q;
    logic             neg2_q;
    logic [WIDTH-1:0] opnd_q;   // multiplicand or divisor magnitude
    logic [WIDTH-1:0] hi_q;     // product high half / partial remainder
    logic [WIDTH-1:0] lo_q;     // multiplier shifting out / dividend shifting out, quotient shifting in
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] ans_q;
    logic             error_q;
    logic             out_valid_q;

    logic [WIDTH-1:0] sf_mag1;
    logic [WIDTH-1:0] sf_mag2;
    logic             sf_neg1;
    logic             sf_neg2;
    logic [WIDTH-1:0] sf_result;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;

    logic             div_zero;
    logic             div_ovf;

    // One iteration of the shared datapath. The remainder is always below the
    // divisor, so div_shift < 2*divisor and bit WIDTH of the difference is a
    // clean borrow flag.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (is_div(mode_q)) begin
            if (!div_diff[WIDTH]) begin
                hi_n = div_diff[WIDTH-1:0];
                lo_n = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_n = div_shift[WIDTH-1:0];
                lo_n = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            {hi_n, lo_n} = {mul_sum, lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        div_zero = is_div(bus.mode_sel) && (bus.num2 == '0);
        div_ovf  = ((bus.mode_sel == MODE_DIV) || (bus.mode_sel == MODE_REM)) &&
                   (bus.num1 == MIN_NEG) && (bus.num2 == '1);
    end

    muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
        .mode     (bus.mode_sel),
        .num1     (bus.num1),
        .num2     (bus.num2),
        .mag1     (sf_mag1),
        .mag2     (sf_mag2),
        .neg1     (sf_neg1),
        .neg2     (sf_neg2),
        .fin_mode (mode_q),
        .fin_neg1 (neg1_q),
        .fin_neg2 (neg2_q),
        .prod     ({hi_n, lo_n}),
        .quot     (lo_n),
        .rem      (hi_n),
        .result   (sf_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mode_q      <= '0;
            neg1_q      <= 1'b0;
            neg2_q      <= 1'b0;
            opnd_q      <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            cnt         <= '0;
            ans_q       <= '0;
            error_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            // ans/error deliberately keep their last values.
            state       <= IDLE;
            cnt         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mode_q <= bus.mode_sel;
                        neg1_q <= sf_neg1;
                        neg2_q <= sf_neg2;
                        cnt    <= CNT_W'(WIDTH);
                        hi_q   <= '0;
                        if (is_div(bus.mode_sel)) begin
                            opnd_q <= sf_mag2;
                            lo_q   <= sf_mag1;
                        end else begin
                            opnd_q <= sf_mag1;
                            lo_q   <= sf_mag2;
                        end
                        if (!is_legal(bus.mode_sel)) begin
                            state       <= DONE;
                            ans_q       <= '0;
                            error_q     <= 1'b1;
                            out_valid_q <= 1'b1;
                        end else if (div_zero) begin
                            state       <= DONE;
                            ans_q       <= is_rem(bus.mode_sel) ? bus.num1 : '1;
                            error_q     <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else if (div_ovf) begin
                            state       <= DONE;
                            ans_q       <= is_rem(bus.mode_sel) ? '0 : bus.num1;
                            error_q     <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state   <= CALC;
                            error_q <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    hi_q <= hi_n;
                    lo_q <= lo_n;
                    cnt  <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        ans_q       <= sf_result;
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.ans       = ans_q;
    assign bus.error     = error_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit: directed cases, random ops vs arithmetic model, flush/reset
module tb_muldiv_unit;

    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(WIDTH)) bus ();

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic straight from the RV32M rules using 64-bit math.
    // lat counts clock edges from the accepting edge (inclusive) until out_valid is seen.
    function automatic void ref_model(input logic [7:0] m, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic e, output int lat);
        longint sa, sb;
        logic [63:0] ua, ub, p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        r = '0;
        e = 1'b0;
        lat = WIDTH + 1;
        case (m)
            8'h20: begin p = ua * ub; r = p[31:0]; end
            8'h21: begin p = 64'(sa * sb); r = p[63:32]; end
            8'h22: begin p = 64'(sa * longint'(ub)); r = p[63:32]; end
            8'h23: begin p = ua * ub; r = p[63:32]; end
            8'h24: begin
                if (b == 0) begin r = 32'hFFFFFFFF; lat = 1; end
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin r = a; lat = 1; end
                else r = 32'(sa / sb);
            end
            8'h25: begin
                if (b == 0) begin r = 32'hFFFFFFFF; lat = 1; end
                else r = a / b;
            end
            8'h26: begin
                if (b == 0) begin r = a; lat = 1; end
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin r = 0; lat = 1; end
                else r = 32'(sa % sb);
            end
            8'h27: begin
                if (b == 0) begin r = a; lat = 1; end
                else r = a % b;
            end
            default: begin r = 0; e = 1'b1; lat = 1; end
        endcase
    endfunction

    task automatic start_op(input logic [7:0] m, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        chk("in_ready before accept", 64'(bus.in_ready), 64'(1));
        bus.mode_sel = m;
        bus.num1     = a;
        bus.num2     = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [7:0] m, input logic [31:0] a, input logic [31:0] b,
                          input string tag, output logic [31:0] got);
        logic [31:0] er;
        logic        ee;
        int          el;
        int          edges;
        logic        busy_ok;
        ref_model(m, a, b, er, ee, el);
        start_op(m, a, b);
        edges = 1;
        busy_ok = 1'b1;
        while (!bus.out_valid && edges < 200) begin
            if (bus.in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            edges++;
        end
        if (bus.in_ready) busy_ok = 1'b0;
        chk({tag, " latency"}, 64'(edges), 64'(el));
        chk({tag, " in_ready low while busy"}, 64'(busy_ok), 64'(1));
        chk({tag, " ans"}, 64'(bus.ans), 64'(er));
        chk({tag, " error"}, 64'(bus.error), 64'(ee));
        got = bus.ans;
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, " out_valid after handshake"}, 64'(bus.out_valid), 64'(0));
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    logic [7:0]  d_mode [12] = '{8'h20, 8'h23, 8'h21, 8'h22, 8'h24, 8'h26,
                                 8'h25, 8'h27, 8'h24, 8'h27, 8'h24, 8'h26};
    logic [31:0] d_a    [12] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                 32'd7, 32'd7, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] d_b    [12] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
                                 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] d_exp  [12] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                 32'd3, 32'd1, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};

    initial begin
        logic [31:0] got;
        logic [7:0]  m;
        logic        seen;

        rst = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.mode_sel = '0;
        bus.num1 = '0;
        bus.num2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", 64'(bus.in_ready), 64'(1));
        chk("reset out_valid", 64'(bus.out_valid), 64'(0));
        chk("reset ans", 64'(bus.ans), 64'(0));
        chk("reset error", 64'(bus.error), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(d_mode[i], d_a[i], d_b[i], $sformatf("directed%0d", i), got);
            chk($sformatf("directed%0d table value", i), 64'(got), 64'(d_exp[i]));
        end

        // Illegal mode, then hold the result under backpressure while a new request is offered.
        start_op(8'h05, 32'h1234, 32'h5678);
        chk("illegal out_valid after 1 edge", 64'(bus.out_valid), 64'(1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.mode_sel = 8'h20;
            bus.num1 = 32'd3;
            bus.num2 = 32'd4;
            @(posedge clk);
            #1;
            chk("hold out_valid", 64'(bus.out_valid), 64'(1));
            chk("hold ans", 64'(bus.ans), 64'(0));
            chk("hold error", 64'(bus.error), 64'(1));
            chk("hold in_ready", 64'(bus.in_ready), 64'(0));
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("release out_valid", 64'(bus.out_valid), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("no op accepted during hold", 64'(bus.in_ready), 64'(1));

        for (int i = 0; i < 60; i++) begin
            m = ($urandom_range(0, 9) < 9) ? 8'(8'h20 + $urandom_range(0, 7)) : 8'($urandom_range(0, 31));
            run_op(m, pick_operand(), pick_operand(), $sformatf("rand%0d mode %h", i, m), got);
        end

        // Flush at counter=22 (10 iterations after accept).
        run_op(8'h25, 32'd7, 32'd2, "pre-flush DIVU", got);
        start_op(8'h20, $urandom(), $urandom());
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush in_ready", 64'(bus.in_ready), 64'(1));
        chk("flush out_valid", 64'(bus.out_valid), 64'(0));
        chk("flush ans kept", 64'(bus.ans), 64'(3));
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        chk("flush out_valid never rises", 64'(seen), 64'(0));
        chk("flush ans still kept", 64'(bus.ans), 64'(3));

        // Flush coinciding with a request in IDLE discards it.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.mode_sel = 8'h24;
        bus.num1 = 32'd5;
        bus.num2 = 32'd0;
        flush = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        flush = 1'b0;
        chk("flush+in_valid discarded in_ready", 64'(bus.in_ready), 64'(1));
        chk("flush+in_valid discarded out_valid", 64'(bus.out_valid), 64'(0));

        // Reset mid-CALC.
        start_op(8'h23, $urandom(), $urandom());
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst mid-calc ans", 64'(bus.ans), 64'(0));
        chk("rst mid-calc out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst mid-calc in_ready", 64'(bus.in_ready), 64'(1));
        repeat (40) @(posedge clk);
        #1;
        chk("rst mid-calc no late result", 64'(bus.out_valid), 64'(0));

        // Reset mid-DONE after an illegal op.
        start_op(8'hFF, 32'd1, 32'd1);
        chk("pre-rst illegal error", 64'(bus.error), 64'(1));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst mid-done error", 64'(bus.error), 64'(0));
        chk("rst mid-done out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst mid-done in_ready", 64'(bus.in_ready), 64'(1));

        run_op(8'h23, 32'h00010000, 32'h00010000, "recovery MULHU", got);
        chk("recovery MULHU value", 64'(got), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
